sequential_divider: RTL and testbench

8-bit restoring shift-subtract divider, the inverse companion of the lab's shift-add multiplier datapath. It loads a dividend and a divisor from the switches and runs eight shift/compare/subtract iterations on a single Run press. It leaves the quotient in register B and the remainder in register A. It sits at the same top level as the multiplier, behind the same button/switch synchronizers and hex displays.

---
 rtl/sequential_divider_if.sv | 24 ++
 rtl/sequential_divider.sv | 142 ++++++++++++++
 tb/tb_sequential_divider.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/sequential_divider_if.sv
// Handshake/data bundle between the board-level controls and sequential_divider.
// master drives the synchronized buttons and switches; slave is the divider.
interface sequential_divider_if;
  logic       Run;
  logic       LoadB;
  logic       LoadS;
  logic [7:0] SW;
  logic [7:0] Aval;
  logic [7:0] Bval;
  logic [7:0] Sval;
  logic       Busy;
  logic       Done;
  logic       DivZero;

  modport master (
    output Run, LoadB, LoadS, SW,
    input  Aval, Bval, Sval, Busy, Done, DivZero
  );

  modport slave (
    input  Run, LoadB, LoadS, SW,
    output Aval, Bval, Sval, Busy, Done, DivZero
  );
endinterface

// File: rtl/sequential_divider.sv
// 8-bit restoring shift-subtract divider: quotient ends in B, remainder in A.
// Define DIV_SIGNED_EN for two's-complement operands (adds the FIXUP state).
module sequential_divider (
  input  logic                 Clk,
  input  logic                 Reset,
  sequential_divider_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ITER,
`ifdef DIV_SIGNED_EN
    FIXUP,
`endif
    DONE
  } state_t;

  state_t     state, state_next;
  logic [7:0] a_q, b_q, s_q;
  logic [2:0] count_q;
  logic       div_zero_q;
  logic       busy, done;

  logic [7:0] divisor;
  logic [7:0] a_shift;
  logic [8:0] trial;
  logic [7:0] a_next, b_next;

`ifdef DIV_SIGNED_EN
  logic d_neg_q, q_neg_q;
  logic [7:0] b_abs;

  // Magnitudes as unsigned 8-bit; -128 maps to 0x80, which is +128 unsigned.
  assign divisor = s_q[7] ? 8'd0 - s_q : s_q;
  assign b_abs   = b_q[7] ? 8'd0 - b_q : b_q;
`else
  assign divisor = s_q;
`endif

  // One iteration: shift {A,B} left, trial-subtract the divisor from the new A.
  assign a_shift = {a_q[6:0], b_q[7]};
  assign trial   = {1'b0, a_shift} - {1'b0, divisor};
  assign a_next  = trial[8] ? a_shift : trial[7:0];
  assign b_next  = {b_q[6:0], ~trial[8]};

  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE:  if (bus.Run) state_next = CLEAR;
      CLEAR: begin
        busy       = 1'b1;
        state_next = ITER;
      end
      ITER: begin
        busy = 1'b1;
        if (count_q == 3'd7) begin
`ifdef DIV_SIGNED_EN
          state_next = FIXUP;
`else
          state_next = DONE;
`endif
        end
      end
`ifdef DIV_SIGNED_EN
      FIXUP: begin
        busy       = 1'b1;
        state_next = DONE;
      end
`endif
      DONE: begin
        done = 1'b1;
        // Run must drop before another press can start a new division.
        if (!bus.Run) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      a_q        <= 8'd0;
      b_q        <= 8'd0;
      s_q        <= 8'd0;
      count_q    <= 3'd0;
      div_zero_q <= 1'b0;
`ifdef DIV_SIGNED_EN
      d_neg_q    <= 1'b0;
      q_neg_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.LoadB) b_q <= bus.SW;
          if (bus.LoadS) s_q <= bus.SW;
        end
        CLEAR: begin
          a_q        <= 8'd0;
          count_q    <= 3'd0;
          div_zero_q <= (s_q == 8'd0);
`ifdef DIV_SIGNED_EN
          b_q        <= b_abs;
          d_neg_q    <= b_q[7];
          q_neg_q    <= b_q[7] ^ s_q[7];
`endif
        end
        ITER: begin
          a_q     <= a_next;
          b_q     <= b_next;
          count_q <= count_q + 3'd1;
        end
`ifdef DIV_SIGNED_EN
        FIXUP: begin
          // Truncation toward zero: remainder takes the dividend's sign.
          if (q_neg_q) b_q <= 8'd0 - b_q;
          if (d_neg_q) a_q <= 8'd0 - a_q;
        end
`endif
        default: ;
      endcase
    end
  end

  assign bus.Aval    = a_q;
  assign bus.Bval    = b_q;
  assign bus.Sval    = s_q;
  assign bus.Busy    = busy;
  assign bus.Done    = done;
  assign bus.DivZero = div_zero_q;

endmodule

// File: tb/tb_sequential_divider.sv
// Self-checking bench for sequential_divider: directed cases plus random
// operands compared against an arithmetic divide/modulo reference model.
module tb_sequential_divider;

  logic Clk;
  logic Reset;
  int   checks = 0;
  int   errors = 0;

`ifdef DIV_SIGNED_EN
  localparam int LATENCY = 10;
`else
  localparam int LATENCY = 9;
`endif

  sequential_divider_if bus ();

  sequential_divider dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %02h expected %02h", tag, observed, expected);
    end
  endtask

  // Reference: plain integer division. Divide-by-zero follows the
  // shift-subtract outcome (all-ones quotient, remainder = dividend).
  function automatic void model(input logic [7:0] b, input logic [7:0] s,
                                output logic [7:0] q, output logic [7:0] r);
`ifdef DIV_SIGNED_EN
    int bi;
    int si;
    bi = int'($signed(b));
    si = int'($signed(s));
    if (si == 0) begin
      q = b[7] ? 8'h01 : 8'hFF;
      r = b;
    end else begin
      q = 8'(bi / si);
      r = 8'(bi % si);
    end
`else
    if (s == 8'd0) begin
      q = 8'hFF;
      r = b;
    end else begin
      q = b / s;
      r = b % s;
    end
`endif
  endfunction

  task automatic load(input logic [7:0] b, input logic [7:0] s);
    @(negedge Clk);
    bus.LoadB = 1'b1;
    bus.SW    = b;
    @(negedge Clk);
    bus.LoadB = 1'b0;
    bus.LoadS = 1'b1;
    bus.SW    = s;
    @(negedge Clk);
    bus.LoadS = 1'b0;
    check("load_b", bus.Bval, b);
    check("load_s", bus.Sval, s);
  endtask

  // Returns at the negedge following the sampling edge (CLEAR cycle).
  task automatic start(input bit hold);
    @(negedge Clk);
    bus.Run = 1'b1;
    @(negedge Clk);
    if (!hold) bus.Run = 1'b0;
    check("busy_clear", 8'(bus.Busy), 8'd1);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (bus.Done !== 1'b1 && lat < 40) begin
      @(negedge Clk);
      lat++;
    end
  endtask

  task automatic divide(input string tag, input logic [7:0] b, input logic [7:0] s);
    logic [7:0] q, r;
    int lat;
    model(b, s, q, r);
    load(b, s);
    start(1'b0);
    wait_done(lat);
    check({tag, "_latency"}, 8'(lat), 8'(LATENCY));
    check({tag, "_quot"}, bus.Bval, q);
    check({tag, "_rem"}, bus.Aval, r);
    check({tag, "_divzero"}, 8'(bus.DivZero), 8'(s == 8'd0));
    check({tag, "_sval"}, bus.Sval, s);
  endtask

  initial begin
    logic [7:0] q1, r1, q2, r2, b, s;
    int lat;

    Reset     = 1'b1;
    bus.Run   = 1'b0;
    bus.LoadB = 1'b0;
    bus.LoadS = 1'b0;
    bus.SW    = 8'h00;
    repeat (2) @(negedge Clk);
    check("rst_aval", bus.Aval, 8'h00);
    check("rst_bval", bus.Bval, 8'h00);
    check("rst_sval", bus.Sval, 8'h00);
    check("rst_busy", 8'(bus.Busy), 8'd0);
    check("rst_done", 8'(bus.Done), 8'd0);
    check("rst_divzero", 8'(bus.DivZero), 8'd0);
    Reset = 1'b0;

    divide("d100_7", 8'h64, 8'h07);
`ifndef DIV_SIGNED_EN
    divide("dff_1", 8'hFF, 8'h01);
`endif
    divide("d3_9", 8'h03, 8'h09);
    divide("d5_0", 8'h05, 8'h00);
    divide("d5_1", 8'h05, 8'h01);

    // Run held high: exactly one division, then a re-press divides the quotient.
    model(8'h48, 8'h03, q1, r1);
    model(q1, 8'h03, q2, r2);
    load(8'h48, 8'h03);
    start(1'b1);
    wait_done(lat);
    check("hold_latency", 8'(lat), 8'(LATENCY));
    repeat (30) @(negedge Clk);
    check("hold_done", 8'(bus.Done), 8'd1);
    check("hold_busy", 8'(bus.Busy), 8'd0);
    check("hold_quot", bus.Bval, q1);
    check("hold_rem", bus.Aval, r1);
    bus.Run = 1'b0;
    @(negedge Clk);
    check("release_done", 8'(bus.Done), 8'd0);
    start(1'b0);
    wait_done(lat);
    check("repress_quot", bus.Bval, q2);
    check("repress_rem", bus.Aval, r2);

    // Reset in the middle of the iterations aborts everything.
    load(8'h64, 8'h07);
    start(1'b0);
    repeat (4) @(negedge Clk);
    check("mid_busy", 8'(bus.Busy), 8'd1);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    check("abort_aval", bus.Aval, 8'h00);
    check("abort_bval", bus.Bval, 8'h00);
    check("abort_sval", bus.Sval, 8'h00);
    check("abort_busy", 8'(bus.Busy), 8'd0);
    check("abort_done", 8'(bus.Done), 8'd0);
    @(negedge Clk);
    check("abort_idle", 8'(bus.Busy), 8'd0);

    // Loads while busy must not disturb the operands.
    model(8'h64, 8'h07, q1, r1);
    load(8'h64, 8'h07);
    start(1'b0);
    bus.LoadB = 1'b1;
    bus.LoadS = 1'b1;
    bus.SW    = 8'hAA;
    @(negedge Clk);
    bus.LoadB = 1'b0;
    bus.LoadS = 1'b0;
    wait_done(lat);
    check("busyload_quot", bus.Bval, q1);
    check("busyload_rem", bus.Aval, r1);
    check("busyload_sval", bus.Sval, 8'h07);

`ifdef DIV_SIGNED_EN
    divide("sg_m100_7", 8'h9C, 8'h07);
    divide("sg_m128_m1", 8'h80, 8'hFF);
    divide("sg_100_m7", 8'h64, 8'hF9);
`endif

    // Random operands; unsigned divisors stay within 0..128 where the 8-bit
    // partial remainder cannot overflow on its shift.
    for (int i = 0; i < 24; i++) begin
      b = 8'($urandom_range(0, 255));
`ifdef DIV_SIGNED_EN
      s = 8'($urandom_range(0, 255));
`else
      s = 8'($urandom_range(0, 128));
`endif
      if (i % 8 == 3) s = 8'h00;
      divide($sformatf("rand%0d", i), b, s);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
